mouse_packet_receiver: RTL
==========================

MOUSE_PACKET_RECEIVER -- requirements
Module: mouse_packet_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, the maximum number of clk cycles allowed between PS/2 falling edges inside one frame.
REQ-002 SHALL have parameter X_MAX, default 639, the upper clamp for x.
REQ-003 SHALL have parameter Y_MAX, default 479, the upper clamp for y.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mouse_clk, input, 1 bit: raw PS/2 clock from the device, asynchronous to clk.
REQ-007 SHALL have port mouse_data, input, 1 bit: raw PS/2 data from the device, asynchronous to clk.
REQ-008 SHALL have port x, output, 16 bits: accumulated cursor column, unsigned.
REQ-009 SHALL have port y, output, 16 bits: accumulated cursor row, unsigned, screen-down positive.
REQ-010 SHALL have port left_button, middle_button and right_button, each output, 1 bit: button levels from the last accepted packet.
REQ-011 SHALL have port x_overflow and y_overflow, each output, 1 bit: overflow flags from the last accepted packet.
REQ-012 SHALL have port data_ready, output, 1 bit: one-cycle pulse when x, y and the button outputs update.
REQ-013 SHALL have port left_click and right_click, each output, 1 bit: one-cycle pulse on a 0->1 transition of that button between packets.
REQ-014 SHALL have port frame_error, output, 1 bit: one-cycle pulse on a parity, start, stop, alignment or timeout error.

Function
REQ-015 SHALL pass mouse_clk and mouse_data through two flops each, then detect a PS/2 falling edge as synchronized clk going from previous 1 to current 0.
REQ-016 SHALL sample data on each falling edge through the frame: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1, for 11 edges per byte.
REQ-017 SHALL use byte-receiver states IDLE, DATA, PARITY and STOP; a sampled start bit of 1 in IDLE is ignored and raises no error.
REQ-018 SHALL treat a byte as bad when parity is wrong or the stop bit is 0: the byte is discarded, frame_error pulses, and packet assembly returns to byte 0.
REQ-019 SHALL count clk cycles while not in IDLE, reload the counter on every falling edge, and on reaching TIMEOUT_CYCLES abort to IDLE, pulse frame_error and return packet assembly to byte 0.
REQ-020 SHALL use packet-assembly states BYTE0, BYTE1 and BYTE2.
REQ-021 SHALL accept a byte in BYTE0 only when bit3 = 1; otherwise the byte is dropped with a frame_error pulse and assembly stays in BYTE0.
REQ-022 SHALL decode byte0 as: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-023 SHALL form dx as the 9-bit signed value {Xsign, byte1} and dy as {Ysign, byte2}.
REQ-024 SHALL, one cycle after byte2 is accepted, compute x_next = clamp(x + dx, 0, X_MAX) and y_next = clamp(y - dy, 0, Y_MAX) using at least 17-bit signed arithmetic, with no wrap-around.
REQ-025 SHALL leave the coordinate unchanged for an axis whose overflow bit is set, while still updating that axis's overflow output.
REQ-026 SHALL update x, y, the button outputs and the overflow outputs in the same cycle that data_ready pulses, which is exactly one pulse per accepted packet.
REQ-027 SHALL compute left_click and right_click against the button state of the previous accepted packet, pulsing coincident with data_ready.
REQ-028 SHALL let a byte completing on the same cycle as a timeout take priority, with the timeout ignored.

Reset
REQ-029 SHALL, on rst_n = 0, asynchronously set x = X_MAX/2 (319) and y = Y_MAX/2 (239).
REQ-030 SHALL, on rst_n = 0, clear all buttons, overflows and pulse outputs to 0, set the byte receiver to IDLE and packet assembly to BYTE0, clear the timeout counter, and set the synchronizers to 1.
REQ-031 SHALL, when reset is asserted mid-frame or mid-packet, discard the partial data and produce no data_ready after release.

Structure
REQ-032 SHALL place the byte0 bit positions, the frame length (11) and the state encodings in a shared package ps2_pkg.
REQ-033 SHALL implement the byte framing (REQ-015 to REQ-019) as the sub-module ps2_byte_receiver, which outputs byte[7:0], byte_valid and byte_error.

Verification
REQ-034 SHALL cover: after reset, packet 0x09, 0x05, 0x03 -> data_ready once; x = 324, y = 236, left_button = 1, left_click = 1.
REQ-035 SHALL cover: packet 0x18, 0xF6, 0x00 (dx = -10) sent 40 times from x = 319 -> x clamps at 0, with no wrap to 65535.
REQ-036 SHALL cover: byte1 sent with a wrong parity bit -> frame_error pulses, no data_ready, and the next valid 3-byte packet is decoded correctly.
REQ-037 SHALL cover: 5 data bits sent, then PS/2 clock idle for 6000 cycles -> frame_error after TIMEOUT_CYCLES, after which a clean packet is accepted.
REQ-038 SHALL cover: byte0 = 0x02 (bit3 = 0) -> frame_error and the byte is dropped; a following 0x0A, 0x00, 0x00 -> right_click = 1, x and y unchanged.
REQ-039 SHALL cover: packet 0x48, 0x7F, 0x01 -> x_overflow = 1, x unchanged, y decremented by 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 mouse constants, byte0 bit positions, state encodings and clamp helper.
package ps2_pkg;
  localparam int FRAME_LEN = 11;
  localparam int DATA_BITS = FRAME_LEN - 3;
  localparam int B0_L      = 0;
  localparam int B0_R      = 1;
  localparam int B0_M      = 2;
  localparam int B0_SYNC   = 3;
  localparam int B0_XS     = 4;
  localparam int B0_YS     = 5;
  localparam int B0_XO     = 6;
  localparam int B0_YO     = 7;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_state_e;
  function automatic logic [15:0] clamp(input int v, input int max);
    return v < 0 ? 16'd0 : v > max ? 16'(max) : 16'(v);
  endfunction
endpackage

// File: rtl/ps2_byte_receiver.sv
// ps2_byte_receiver: synchronizes raw PS/2 clk/data and frames 11-bit bytes with parity/stop/timeout checks.
// Ports: clk, rst_n (async active-low); mouse_clk, mouse_data (raw, async);
//        data_byte (last good byte), byte_valid (1-cycle pulse), byte_error (1-cycle pulse).
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mouse_clk,
  input  logic       mouse_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       byte_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  rx_state_e state_q, state_d;
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic par_q, par_d, valid_q, valid_d, error_q, error_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic fall, din, timeout, good;
  // clk_sync_q[2] is the previous synchronized level, used only for edge detection
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign din     = dat_sync_q[1];
  assign timeout = state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES);
  assign good    = din & ^{shift_q, par_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end
  // a falling edge always wins over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    if (fall)
      case (state_q)
        IDLE:    state_d = din ? IDLE : DATA;
        DATA:    state_d = bit_cnt_q == 3'(DATA_BITS - 1) ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    else if (timeout)
      state_d = IDLE;
  end
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], mouse_clk};
    dat_sync_d = {dat_sync_q[0], mouse_data};
    tmo_d      = (fall || timeout || state_q == IDLE) ? '0 : tmo_q + TW'(1);
    bit_cnt_d  = state_q == IDLE ? 3'd0 : (fall && state_q == DATA) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    shift_d    = (fall && state_q == DATA) ? {din, shift_q[7:1]} : shift_q;
    par_d      = (fall && state_q == PARITY) ? din : par_q;
    valid_d    = fall && state_q == STOP && good;
    error_d    = (fall && state_q == STOP && !good) || (!fall && timeout);
    byte_d     = valid_d ? shift_q : byte_q;
  end
  assign data_byte  = byte_q;
  assign byte_valid = valid_q;
  assign byte_error = error_q;
endmodule

// File: rtl/mouse_packet_receiver.sv
// mouse_packet_receiver: assembles 3-byte PS/2 mouse packets into clamped cursor position and button state.
// Ports: clk, rst_n (async active-low); mouse_clk, mouse_data (raw PS/2);
//        x, y (cursor), left/middle/right_button, x/y_overflow (last packet levels);
//        data_ready, left_click, right_click, frame_error (1-cycle pulses).
module mouse_packet_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mouse_clk,
  input  logic        mouse_data,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        left_button,
  output logic        middle_button,
  output logic        right_button,
  output logic        x_overflow,
  output logic        y_overflow,
  output logic        data_ready,
  output logic        left_click,
  output logic        right_click,
  output logic        frame_error
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_error;
  ps2_byte_receiver #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .mouse_clk  (mouse_clk),
    .mouse_data (mouse_data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .byte_error (rx_error)
  );
  pkt_state_e state_q, state_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic pkt_q, pkt_d, fe_q, fe_d, dr_q, dr_d, lc_q, lc_d, rc_q, rc_d;
  logic l_q, l_d, m_q, m_d, r_q, r_d, xo_q, xo_d, yo_q, yo_d;
  logic signed [8:0] dx, dy;
  logic signed [17:0] x_sum, y_sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BYTE0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      pkt_q   <= 1'b0;
      fe_q    <= 1'b0;
      dr_q    <= 1'b0;
      lc_q    <= 1'b0;
      rc_q    <= 1'b0;
      x_q     <= 16'(X_MAX / 2);
      y_q     <= 16'(Y_MAX / 2);
      l_q     <= 1'b0;
      m_q     <= 1'b0;
      r_q     <= 1'b0;
      xo_q    <= 1'b0;
      yo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      pkt_q   <= pkt_d;
      fe_q    <= fe_d;
      dr_q    <= dr_d;
      lc_q    <= lc_d;
      rc_q    <= rc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      l_q     <= l_d;
      m_q     <= m_d;
      r_q     <= r_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end
  // byte0 without the sync bit is dropped so the stream can realign
  always_comb begin
    state_d = rx_error ? BYTE0 :
              !rx_valid ? state_q :
              state_q == BYTE0 ? (rx_byte[B0_SYNC] ? BYTE1 : BYTE0) :
              state_q == BYTE1 ? BYTE2 : BYTE0;
  end
  always_comb begin
    fe_d  = rx_error | (rx_valid && state_q == BYTE0 && !rx_byte[B0_SYNC]);
    b0_d  = (rx_valid && state_q == BYTE0) ? rx_byte : b0_q;
    b1_d  = (rx_valid && state_q == BYTE1) ? rx_byte : b1_q;
    b2_d  = (rx_valid && state_q == BYTE2) ? rx_byte : b2_q;
    pkt_d = rx_valid && state_q == BYTE2 && b0_q[B0_SYNC];
    dx    = {b0_q[B0_XS], b1_q};
    dy    = {b0_q[B0_YS], b2_q};
    x_sum = $signed({2'b00, x_q}) + 18'(dx);
    y_sum = $signed({2'b00, y_q}) - 18'(dy);
    x_d   = (pkt_q && !b0_q[B0_XO]) ? clamp(int'(x_sum), X_MAX) : x_q;
    y_d   = (pkt_q && !b0_q[B0_YO]) ? clamp(int'(y_sum), Y_MAX) : y_q;
    l_d   = pkt_q ? b0_q[B0_L] : l_q;
    m_d   = pkt_q ? b0_q[B0_M] : m_q;
    r_d   = pkt_q ? b0_q[B0_R] : r_q;
    xo_d  = pkt_q ? b0_q[B0_XO] : xo_q;
    yo_d  = pkt_q ? b0_q[B0_YO] : yo_q;
    dr_d  = pkt_q;
    lc_d  = pkt_q && b0_q[B0_L] && !l_q;
    rc_d  = pkt_q && b0_q[B0_R] && !r_q;
  end
  assign x             = x_q;
  assign y             = y_q;
  assign left_button   = l_q;
  assign middle_button = m_q;
  assign right_button  = r_q;
  assign x_overflow    = xo_q;
  assign y_overflow    = yo_q;
  assign data_ready    = dr_q;
  assign left_click    = lc_q;
  assign right_click   = rc_q;
  assign frame_error   = fe_q;
endmodule
